line_burst_adapter: RTL and testbench
=====================================

// Module: line_burst_adapter
// PURPOSE
//  Upstream fill/writeback engine for the cache data array. Converts one
//  whole-line request from the cache controller into a fixed-length burst on
//  the memory port (beat = s_beat bits). On a fill, it assembles the beats
//  and writes the full line into the data array in one load cycle. On a
//  writeback, it slices the captured victim line into beats for memory.
// PARAMETERS
//  s_offset  5   log2 bytes per line; s_mask = 2**s_offset, s_line = 8*s_mask
//  s_index   3   set index width; matches the data array
//  s_beat    64  memory beat width; BEATS = s_line/s_beat (4 at defaults), power of 2
// PORTS
//  clk           in   1        clock
//  rst           in   1        reset, synchronous, active-high
//  req_valid     in   1        line request present
//  req_write     in   1        1 = writeback, 0 = fill
//  req_addr      in   32       byte address; low s_offset bits ignored
//  req_index     in   s_index  set to fill; ignored on writeback
//  req_wdata     in   s_line   victim line; ignored on fill
//  req_ready     out  1        adapter idle, can accept a request
//  line_done     out  1        1-cycle pulse when the request completes
//  arr_load      out  1        data array load strobe
//  arr_write_en  out  s_mask   byte write mask to the array
//  arr_windex    out  s_index  array write index
//  arr_datain    out  s_line   assembled fill line
//  mem_read      out  1        memory read burst active
//  mem_write     out  1        memory write burst active
//  mem_addr      out  32       line-aligned burst address
//  mem_wdata     out  s_beat   current write beat
//  mem_rdata     in   s_beat   current read beat
//  mem_resp      in   1        beat accepted/returned this cycle
// BEHAVIOUR
//  - FSM states: IDLE, RD_BURST, WR_BURST, DONE. All outputs are registered or
//    decoded from registered state only.
//  - Reset: state=IDLE, beat_cnt=0, line buffer=0. req_ready=1. All other
//    outputs are 0.
//  - Reset mid-burst: the next edge returns to IDLE. mem_read and mem_write
//    drop. No arr_load and no line_done are issued.
//  - Accept: in IDLE with req_valid=1. Capture {req_addr[31:s_offset], s_offset'0},
//    req_index, req_write and req_wdata. Go to RD_BURST (fill) or WR_BURST
//    (writeback). req_ready=0 in every state except IDLE. req_valid outside IDLE
//    is ignored.
//  - RD_BURST: mem_read=1 and mem_addr=captured line address, held until the last
//    beat. On each mem_resp, write mem_rdata to buffer[beat_cnt*s_beat +: s_beat],
//    then beat_cnt++. Beat 0 is the LSBs. On the resp with beat_cnt==BEATS-1,
//    go to DONE and wrap beat_cnt to 0.
//  - WR_BURST: mem_write=1 and mem_addr=line address.
//    mem_wdata = wdata[beat_cnt*s_beat +: s_beat]. Advance on mem_resp. The last
//    resp goes to DONE and wraps beat_cnt to 0.
//  - Cycles without mem_resp (stalls) hold all state. There is no timeout.
//  - mem_resp in IDLE or DONE is ignored.
//  - DONE (1 cycle): line_done=1, then IDLE.
//  - DONE on a fill: additionally arr_load=1, arr_write_en=all ones,
//    arr_windex=captured index, arr_datain=buffer.
//  - DONE on a writeback: arr_load=0.
//  - arr_datain and arr_windex hold their last values outside DONE.
//    arr_write_en=0 outside DONE.
//  - Latency: fill = accept + BEATS resp cycles + 1. Minimum accept-to-line_done
//    is BEATS+1 cycles. req_ready is back the cycle after line_done.
//  - A same-cycle array read of the filled set is served by the data array's own
//    forwarding. This block adds no bypass.
// TESTING
//  1 Fill: addr=0x0000_1234, index=3, beats 0x11..,0x22..,0x33..,0x44..
//    with resp every cycle. Required: mem_addr=0x0000_1220. Exactly one
//    arr_load with windex=3 and write_en=32'hFFFF_FFFF. datain[63:0]=beat0 and
//    datain[255:192]=beat3. line_done in the same cycle.
//  2 Writeback: wdata={64'hD,64'hC,64'hB,64'hA}, resp with 2-cycle gaps.
//    Required: mem_wdata sequence A,B,C,D, each held through its stall. mem_write
//    drops after the 4th resp. arr_load never asserts. One line_done pulse.
//  3 Back-to-back: fill then writeback, with req_valid held high.
//    Required: the second request is accepted only in the cycle after line_done.
//    Captured fields are not disturbed by req changes while busy.
//  4 Reset after 2 fill beats: assert rst for 1 cycle.
//    Required: next cycle is IDLE with req_ready=1, mem_read=0, arr_load=0,
//    line_done=0. A following fill assembles fresh beats, with no stale data
//    from the aborted fill.
//  5 Spurious mem_resp in IDLE for 3 cycles, then a fill.
//    Required: no state change. The fill still takes exactly 4 resps.
//  6 Fill to index 7 (the top set).
//    Required: arr_windex=7, and the count wrap leaves beat_cnt=0 for the next
//    request.

Source files
------------

// File: rtl/line_burst_adapter.sv
// Line fill/writeback adapter: turns one whole-line request into a fixed-length
// memory burst, assembling fill beats into a line or slicing a victim into beats.
module line_burst_adapter #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int s_beat   = 64,
   localparam int s_mask  = 2**s_offset,
   localparam int s_line  = 8*s_mask,
   localparam int BEATS   = s_line/s_beat,
   localparam int CW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic               req_write,
   input  logic [31:0]        req_addr,
   input  logic [s_index-1:0] req_index,
   input  logic [s_line-1:0]  req_wdata,
   output logic               req_ready,
   output logic               line_done,
   output logic               arr_load,
   output logic [s_mask-1:0]  arr_write_en,
   output logic [s_index-1:0] arr_windex,
   output logic [s_line-1:0]  arr_datain,
   output logic               mem_read,
   output logic               mem_write,
   output logic [31:0]        mem_addr,
   output logic [s_beat-1:0]  mem_wdata,
   input  logic [s_beat-1:0]  mem_rdata,
   input  logic               mem_resp,
   output logic [1:0]         dbg_state,
   output logic [CW-1:0]      dbg_beat_cnt
);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
   logic [s_line-1:0]  buf_q, buf_d;
   logic [s_line-1:0]  wdata_q, wdata_d;
   logic [31:0]        addr_q, addr_d;
   logic [s_index-1:0] index_q, index_d;
   logic               write_q, write_d;
   logic [s_line-1:0]  arr_datain_q, arr_datain_d;
   logic [s_index-1:0] arr_windex_q, arr_windex_d;
   logic               last_beat;

   assign last_beat = (beat_cnt_q == CW'(BEATS-1));

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      buf_d        = buf_q;
      wdata_d      = wdata_q;
      addr_d       = addr_q;
      index_d      = index_q;
      write_d      = write_q;
      arr_datain_d = arr_datain_q;
      arr_windex_d = arr_windex_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d     = {req_addr[31:s_offset], {s_offset{1'b0}}};
               index_d    = req_index;
               write_d    = req_write;
               wdata_d    = req_wdata;
               beat_cnt_d = '0;
               state_d    = req_write ? WR_BURST : RD_BURST;
            end
         end
         RD_BURST: begin
            if (mem_resp) begin
               buf_d[beat_cnt_q*s_beat +: s_beat] = mem_rdata;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (last_beat) begin
                  // Latch the completed line so the array port holds it after DONE.
                  arr_datain_d = buf_d;
                  arr_windex_d = index_q;
                  state_d      = DONE;
               end
            end
         end
         WR_BURST: begin
            if (mem_resp) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (last_beat) state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         buf_q        <= '0;
         wdata_q      <= '0;
         addr_q       <= '0;
         index_q      <= '0;
         write_q      <= 1'b0;
         arr_datain_q <= '0;
         arr_windex_q <= '0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         buf_q        <= buf_d;
         wdata_q      <= wdata_d;
         addr_q       <= addr_d;
         index_q      <= index_d;
         write_q      <= write_d;
         arr_datain_q <= arr_datain_d;
         arr_windex_q <= arr_windex_d;
      end
   end

   // Every output is a decode of registered state.
   assign req_ready    = (state_q == IDLE);
   assign line_done    = (state_q == DONE);
   assign arr_load     = (state_q == DONE) && !write_q;
   assign arr_write_en = arr_load ? {s_mask{1'b1}} : '0;
   assign arr_windex   = arr_windex_q;
   assign arr_datain   = arr_datain_q;
   assign mem_read     = (state_q == RD_BURST);
   assign mem_write    = (state_q == WR_BURST);
   assign mem_addr     = (mem_read || mem_write) ? addr_q : 32'h0;
   assign mem_wdata    = mem_write ? wdata_q[beat_cnt_q*s_beat +: s_beat] : '0;
   assign dbg_state    = state_q;
   assign dbg_beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: cycle vectors for fill, writeback,
// idle resp and top-set fill, plus sequences for back-to-back and mid-burst reset.
module tb_line_burst_adapter;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic         req_write;
   logic [31:0]  req_addr;
   logic [2:0]   req_index;
   logic [255:0] req_wdata;
   logic         req_ready;
   logic         line_done;
   logic         arr_load;
   logic [31:0]  arr_write_en;
   logic [2:0]   arr_windex;
   logic [255:0] arr_datain;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_addr;
   logic [63:0]  mem_wdata;
   logic [63:0]  mem_rdata;
   logic         mem_resp;
   logic [1:0]   dbg_state;
   logic [1:0]   dbg_beat_cnt;

   int n_vec = 0;
   int n_err = 0;

   line_burst_adapter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_index(req_index), .req_wdata(req_wdata), .req_ready(req_ready),
      .line_done(line_done), .arr_load(arr_load), .arr_write_en(arr_write_en),
      .arr_windex(arr_windex), .arr_datain(arr_datain),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, valid, write;
      logic [31:0] addr;
      logic [2:0]  idx;
      logic        resp;
      logic [63:0] rdata;
      logic        e_ready, e_done, e_load, e_rd, e_wr;
      logic [31:0] e_addr;
      logic [63:0] e_wdata;
      logic [2:0]  e_windex;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, va, wr, input logic [31:0] ad,
                               input logic [2:0] ix, input logic rs,
                               input logic [63:0] rd,
                               input logic erdy, edn, eld, erd, ewr,
                               input logic [31:0] ead, input logic [63:0] ewd,
                               input logic [2:0] ewi);
      vec_t v;
      v.rst = r; v.valid = va; v.write = wr; v.addr = ad; v.idx = ix;
      v.resp = rs; v.rdata = rd;
      v.e_ready = erdy; v.e_done = edn; v.e_load = eld; v.e_rd = erd; v.e_wr = ewr;
      v.e_addr = ead; v.e_wdata = ewd; v.e_windex = ewi;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input int id, input vec_t v);
      logic [31:0] e_wen;
      rst = v.rst; req_valid = v.valid; req_write = v.write; req_addr = v.addr;
      req_index = v.idx; mem_resp = v.resp; mem_rdata = v.rdata;
      step();
      e_wen = v.e_load ? 32'hFFFF_FFFF : 32'h0;
      n_vec++;
      if (req_ready !== v.e_ready || line_done !== v.e_done || arr_load !== v.e_load ||
          arr_write_en !== e_wen || mem_read !== v.e_rd || mem_write !== v.e_wr ||
          mem_addr !== v.e_addr || mem_wdata !== v.e_wdata || arr_windex !== v.e_windex) begin
         n_err++;
         $display("FAIL vec%0d: got rdy=%b done=%b load=%b wen=%h rd=%b wr=%b addr=%h wdata=%h windex=%0d, need rdy=%b done=%b load=%b wen=%h rd=%b wr=%b addr=%h wdata=%h windex=%0d",
                  id, req_ready, line_done, arr_load, arr_write_en, mem_read, mem_write,
                  mem_addr, mem_wdata, arr_windex, v.e_ready, v.e_done, v.e_load, e_wen,
                  v.e_rd, v.e_wr, v.e_addr, v.e_wdata, v.e_windex);
      end
   endtask

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, need %h", name, act, exp);
      end
   endtask

   localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
   localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
   localparam logic [63:0] WA = 64'hA, WB = 64'hB, WC = 64'hC, WD = 64'hD;

   initial begin
      int n_a;
      logic [255:0] w2, line_exp;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_index = '0;
      req_wdata = {WD, WC, WB, WA}; mem_rdata = '0; mem_resp = 1'b0;
      step();

      // Reset and fill of set 3.
      tbl.push_back(mk(1,0,0,0,0,0,0,             1,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,1,0,32'h1234,3,0,0,      0,0,0,1,0,32'h1220,0,0));
      tbl.push_back(mk(0,0,0,0,0,1,B1,            0,0,0,1,0,32'h1220,0,0));
      tbl.push_back(mk(0,0,0,0,0,1,B2,            0,0,0,1,0,32'h1220,0,0));
      tbl.push_back(mk(0,0,0,0,0,1,B3,            0,0,0,1,0,32'h1220,0,0));
      tbl.push_back(mk(0,0,0,0,0,1,B4,            0,1,1,0,0,0,0,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             1,0,0,0,0,0,0,3));
      n_a = tbl.size();
      // Writeback with two stall cycles before each resp.
      tbl.push_back(mk(0,1,1,32'h2047,1,0,0,      0,0,0,0,1,32'h2040,WA,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,32'h2040,WA,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,32'h2040,WA,3));
      tbl.push_back(mk(0,0,0,0,0,1,0,             0,0,0,0,1,32'h2040,WB,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,32'h2040,WB,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,32'h2040,WB,3));
      tbl.push_back(mk(0,0,0,0,0,1,0,             0,0,0,0,1,32'h2040,WC,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,32'h2040,WC,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,32'h2040,WC,3));
      tbl.push_back(mk(0,0,0,0,0,1,0,             0,0,0,0,1,32'h2040,WD,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,32'h2040,WD,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             0,0,0,0,1,32'h2040,WD,3));
      tbl.push_back(mk(0,0,0,0,0,1,0,             0,1,0,0,0,0,0,3));
      tbl.push_back(mk(0,0,0,0,0,0,0,             1,0,0,0,0,0,0,3));
      // Spurious resps while idle, then a fill to the top set with one stall.
      tbl.push_back(mk(0,0,0,0,0,1,64'hDEAD,      1,0,0,0,0,0,0,3));
      tbl.push_back(mk(0,0,0,0,0,1,64'hDEAD,      1,0,0,0,0,0,0,3));
      tbl.push_back(mk(0,0,0,0,0,1,64'hDEAD,      1,0,0,0,0,0,0,3));
      tbl.push_back(mk(0,1,0,32'hFFFF_FFE5,7,1,64'hDEAD, 0,0,0,1,0,32'hFFFF_FFE0,0,3));
      tbl.push_back(mk(0,0,0,0,0,1,64'h70,        0,0,0,1,0,32'hFFFF_FFE0,0,3));
      tbl.push_back(mk(0,0,0,0,0,0,64'hBEEF,      0,0,0,1,0,32'hFFFF_FFE0,0,3));
      tbl.push_back(mk(0,0,0,0,0,1,64'h71,        0,0,0,1,0,32'hFFFF_FFE0,0,3));
      tbl.push_back(mk(0,0,0,0,0,1,64'h72,        0,0,0,1,0,32'hFFFF_FFE0,0,3));
      tbl.push_back(mk(0,0,0,0,0,1,64'h73,        0,1,1,0,0,0,0,7));
      tbl.push_back(mk(0,0,0,0,0,1,64'hDEAD,      1,0,0,0,0,0,0,7));

      for (int i = 0; i < n_a; i++) apply(i, tbl[i]);
      chk("fill1_datain", arr_datain, {B4, B3, B2, B1});
      for (int i = n_a; i < tbl.size(); i++) apply(i, tbl[i]);
      chk("top_set_datain", arr_datain, {64'h73, 64'h72, 64'h71, 64'h70});
      chk("top_set_cnt_wrap", {254'h0, dbg_beat_cnt}, 256'h0);

      // Back-to-back with req_valid held; request fields change while busy.
      w2 = {64'h4444_0000_0000_0004, 64'h4444_0000_0000_0003,
            64'h4444_0000_0000_0002, 64'h4444_0000_0000_0001};
      mem_resp = 1'b0; req_valid = 1'b1; req_write = 1'b0;
      req_addr = 32'h0000_3010; req_index = 3'd5;
      step();
      chk("b2b_fill_accept", {254'h0, req_ready, mem_read}, {254'h0, 2'b01});
      req_write = 1'b1; req_addr = 32'h0000_4000; req_index = 3'd2; req_wdata = w2;
      for (int i = 0; i < 4; i++) begin
         mem_resp = 1'b1; mem_rdata = 64'h5555_0000_0000_0000 | 64'(i);
         step();
         if (i < 3) chk("b2b_fill_addr", {223'h0, mem_read, mem_addr}, {223'h0, 1'b1, 32'h0000_3000});
         else chk("b2b_fill_done", {252'h0, line_done, arr_load, arr_windex}, {252'h0, 2'b11, 3'd5});
      end
      mem_resp = 1'b0;
      step();
      chk("b2b_ready_after_done", {254'h0, req_ready, mem_write}, {254'h0, 2'b10});
      step();
      chk("b2b_wb_accept", {159'h0, mem_write, mem_addr, mem_wdata},
          {159'h0, 1'b1, 32'h0000_4000, w2[63:0]});
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_resp = 1'b1;
         step();
         if (i < 3) chk("b2b_wb_beat", {192'h0, mem_wdata}, {192'h0, w2[(i+1)*64 +: 64]});
         else chk("b2b_wb_done", {253'h0, line_done, arr_load, mem_write}, {253'h0, 3'b100});
      end
      chk("b2b_fill_datain", arr_datain,
          {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
           64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000});

      // Reset after two fill beats, then a fresh fill.
      mem_resp = 1'b0; req_valid = 1'b1; req_write = 1'b0;
      req_addr = 32'h0000_5000; req_index = 3'd1;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_resp = 1'b1; mem_rdata = 64'hBAD0 | 64'(i);
         step();
      end
      mem_resp = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("reset_mid_burst", {250'h0, req_ready, mem_read, arr_load, line_done, dbg_beat_cnt},
          {250'h0, 6'b100000});
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      line_exp = '0;
      for (int i = 0; i < 4; i++) begin
         mem_resp = 1'b1; mem_rdata = 64'h6000_0000_0000_0000 | 64'(i);
         line_exp[i*64 +: 64] = mem_rdata;
         step();
      end
      mem_resp = 1'b0;
      chk("fresh_fill_done", {252'h0, line_done, arr_load, arr_windex}, {252'h0, 2'b11, 3'd1});
      chk("fresh_fill_datain", arr_datain, line_exp);
      step();
      chk("fresh_fill_idle", {255'h0, req_ready}, {255'h0, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
